// File: rtl/sw_sequencer_if.sv
// Signal bundle between the stimulus loader/bench and sw_sequencer.
// Includes the debug view of the sequencer state.
interface sw_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int LED_W  = 8,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16
);
    localparam int IW = $clog2(DEPTH);

    // Handshake: start is a level that is only sampled in IDLE. cap_valid and
    // done are single-cycle pulses with no backpressure. load_we writes one
    // entry per cycle and is silently dropped unless idle with start low.
    logic              start;
    logic              abort;
    logic [IW:0]       vec_count;
    logic              load_we;
    logic [IW-1:0]     load_addr;
    logic [DATA_W-1:0] load_data;
    logic [HOLD_W-1:0] load_hold;
    logic [LED_W-1:0]  load_expect;
    logic [LED_W-1:0]  led_in;
    logic [DATA_W-1:0] sw_data;
    logic              sw_go;
    logic [LED_W-1:0]  cap_data;
    logic              cap_valid;
    logic              busy;
    logic              done;
    logic [7:0]        mismatch_cnt;
    logic [2:0]        state;

    modport master (
        output start, abort, vec_count, load_we, load_addr, load_data,
               load_hold, load_expect, led_in,
        input  sw_data, sw_go, cap_data, cap_valid, busy, done,
               mismatch_cnt, state
    );

    modport slave (
        input  start, abort, vec_count, load_we, load_addr, load_data,
               load_hold, load_expect, led_in,
        output sw_data, sw_go, cap_data, cap_valid, busy, done,
               mismatch_cnt, state
    );
endinterface

// File: rtl/sw_sequencer.sv
// Replays a table of switch vectors onto picoMIPS SW with timed go pulses and
// captures LED after each handshake. Optional expect checking: SWSEQ_CHECK_EN.
module sw_sequencer #(
    parameter int DATA_W = 8,
    parameter int LED_W  = 8,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16
) (
    input logic         clk,
    input logic         reset,
    sw_sequencer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        GO      = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx, last, last_nx;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic [CW-1:0]     vc_clamp, vc_m1;
    logic              table_we;

    logic [DATA_W-1:0] tbl_data [DEPTH];
    logic [HOLD_W-1:0] tbl_hold [DEPTH];

    logic [DATA_W-1:0] sw_data_q;
    logic [LED_W-1:0]  cap_data_q;
    logic              sw_go_q, cap_valid_q, busy_q, done_q;

    assign table_we = bus.load_we && (state == IDLE) && !bus.start;

    always_ff @(posedge clk) begin
        if (table_we) begin
            tbl_data[bus.load_addr] <= bus.load_data;
            tbl_hold[bus.load_addr] <= bus.load_hold;
        end
    end

    always_comb begin
        vc_clamp = (bus.vec_count > CW'(DEPTH)) ? CW'(DEPTH) : bus.vec_count;
        vc_m1    = vc_clamp - CW'(1);
        state_nx = state;
        idx_nx   = idx;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.vec_count == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SETUP;
                        idx_nx   = '0;
                        cnt_nx   = '0;
                        last_nx  = vc_m1[IW-1:0];
                    end
                end
            end
            // Counter runs 0..hold inclusive, so hold = all-ones never wraps.
            SETUP: begin
                if (cnt == tbl_hold[idx]) begin
                    cnt_nx   = '0;
                    state_nx = GO;
                end else begin
                    cnt_nx = cnt + HOLD_W'(1);
                end
            end
            GO: begin
                if (cnt == tbl_hold[idx]) begin
                    cnt_nx   = '0;
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx = cnt + HOLD_W'(1);
                end
            end
            CAPTURE: begin
                if (idx == last) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + IW'(1);
                    state_nx = SETUP;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort && (state != IDLE)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            last        <= '0;
            cnt         <= '0;
            sw_data_q   <= '0;
            sw_go_q     <= 1'b0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            last        <= last_nx;
            cnt         <= cnt_nx;
            if (state_nx == SETUP) sw_data_q <= tbl_data[idx_nx];
            sw_go_q     <= (state_nx == GO);
            cap_valid_q <= (state_nx == CAPTURE);
            if (state_nx == CAPTURE) cap_data_q <= bus.led_in;
            busy_q      <= (state_nx != IDLE);
            done_q      <= (state_nx == DONE);
        end
    end

    assign bus.sw_data   = sw_data_q;
    assign bus.sw_go     = sw_go_q;
    assign bus.cap_data  = cap_data_q;
    assign bus.cap_valid = cap_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state     = state;

`ifdef SWSEQ_CHECK_EN
    logic [LED_W-1:0] tbl_exp [DEPTH];
    logic [7:0]       mis_q;

    always_ff @(posedge clk) begin
        if (table_we) tbl_exp[bus.load_addr] <= bus.load_expect;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= 8'd0;
        end else if ((state == IDLE) && bus.start) begin
            mis_q <= 8'd0;
        end else if ((state_nx == CAPTURE) && (bus.led_in != tbl_exp[idx])
                     && (mis_q != 8'hFF)) begin
            mis_q <= mis_q + 8'd1;
        end
    end

    assign bus.mismatch_cnt = mis_q;
`else
    logic unused_expect;
    assign unused_expect    = ^bus.load_expect;
    assign bus.mismatch_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_sw_sequencer.sv
// Directed bench for sw_sequencer: stimulus pushes expected captures and done
// cycles into queues; a negedge monitor pops and compares them.
module tb_sw_sequencer;
    localparam int DATA_W = 8;
    localparam int LED_W  = 8;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 16;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sw_sequencer_if #(.DATA_W(DATA_W), .LED_W(LED_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus();

    sw_sequencer #(.DATA_W(DATA_W), .LED_W(LED_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for picoMIPS: LED is a fixed function of the switches.
    logic led_mode;
    assign bus.led_in = led_mode ? 8'h05 : (bus.sw_data ^ 8'h5A);

    // scoreboard
    int checks   = 0;
    int failures = 0;
    logic [LED_W-1:0] exp_q[$];
    int cap_cyc_q[$];
    int done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [LED_W-1:0] e;
        int c;
        if (reset === 1'b0) begin
            if (bus.cap_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("cap_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = cap_cyc_q.pop_front();
                    check("cap_data", 32'(bus.cap_data), 32'(e));
                    check("cap_cycle", cyc, c);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    c = done_q.pop_front();
                    check("done_cycle", cyc, c);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic load(input int addr, input logic [7:0] data, input logic [15:0] hold,
                        input logic [7:0] exp_v);
        bus.load_we     = 1'b1;
        bus.load_addr   = 4'(addr);
        bus.load_data   = data;
        bus.load_hold   = hold;
        bus.load_expect = exp_v;
        step();
        bus.load_we = 1'b0;
    endtask

    task automatic do_start(input int vc, output int t0);
        bus.vec_count = 5'(vc);
        bus.start     = 1'b1;
        t0            = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic push_cap(input logic [7:0] v, input int c);
        exp_q.push_back(v);
        cap_cyc_q.push_back(c);
    endtask

    initial begin
        int t0;
        int t1;
        reset           = 1'b1;
        led_mode        = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.vec_count   = '0;
        bus.load_we     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.load_hold   = '0;
        bus.load_expect = '0;
        step();
        step();
        check("rst_sw_data", 32'(bus.sw_data), 32'd0);
        check("rst_sw_go", 32'(bus.sw_go), 32'd0);
        check("rst_cap_data", 32'(bus.cap_data), 32'd0);
        check("rst_cap_valid", 32'(bus.cap_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mismatch", 32'(bus.mismatch_cnt), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        reset = 1'b0;
        step();

        // vec_count above DEPTH is clamped: 16 entries of hold 0, 3 cycles each
        for (int i = 0; i < DEPTH; i++) load(i, 8'(i * 17), 16'd0, 8'd0);
        do_start(31, t0);
        for (int i = 0; i < DEPTH; i++) push_cap(8'(i * 17) ^ 8'h5A, t0 + 3 * (i + 1));
        done_q.push_back(t0 + 49);
        wait_to(t0 + 50);
        check("clamp_busy_low", 32'(bus.busy), 32'd0);

        // single entry, hold 3
        load(0, 8'h02, 16'd3, 8'd0);
        do_start(1, t0);
        push_cap(8'h02 ^ 8'h5A, t0 + 9);
        done_q.push_back(t0 + 10);
        for (int k = 1; k <= 8; k++) begin
            wait_to(t0 + k);
            check("single_sw_data", 32'(bus.sw_data), 32'h02);
            check("single_sw_go", 32'(bus.sw_go), (k > 4) ? 32'd1 : 32'd0);
        end
        wait_to(t0 + 10);
        check("single_busy_in_done", 32'(bus.busy), 32'd1);
        wait_to(t0 + 11);
        check("single_busy_low", 32'(bus.busy), 32'd0);

        // three entries: captures at 3, 8, 11; done at 12
        load(0, 8'h01, 16'd0, 8'd0);
        load(1, 8'h80, 16'd1, 8'd0);
        load(2, 8'hFF, 16'd0, 8'd0);
        do_start(3, t0);
        push_cap(8'h01 ^ 8'h5A, t0 + 3);
        push_cap(8'h80 ^ 8'h5A, t0 + 8);
        push_cap(8'hFF ^ 8'h5A, t0 + 11);
        done_q.push_back(t0 + 12);
        wait_to(t0 + 13);
        check("three_busy_low", 32'(bus.busy), 32'd0);

        // vec_count = 0 goes straight to DONE
        do_start(0, t0);
        done_q.push_back(t0 + 1);
        check("zero_busy", 32'(bus.busy), 32'd1);
        check("zero_sw_go", 32'(bus.sw_go), 32'd0);
        wait_to(t0 + 2);
        check("zero_busy_low", 32'(bus.busy), 32'd0);
        check("zero_sw_go_late", 32'(bus.sw_go), 32'd0);

        // abort in the second GO, with a dropped write while busy
        load(0, 8'h11, 16'd1, 8'd0);
        load(1, 8'h22, 16'd2, 8'd0);
        load(2, 8'h33, 16'd0, 8'd0);
        do_start(3, t0);
        push_cap(8'h11 ^ 8'h5A, t0 + 5);
        wait_to(t0 + 2);
        load(1, 8'h99, 16'd0, 8'd0);
        wait_to(t0 + 9);
        check("abort_in_go", 32'(bus.sw_go), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sw_go", 32'(bus.sw_go), 32'd0);
        check("abort_state", 32'(bus.state), 32'd0);
        wait_to(t0 + 16);
        do_start(2, t1);
        push_cap(8'h11 ^ 8'h5A, t1 + 5);
        push_cap(8'h22 ^ 8'h5A, t1 + 12);
        done_q.push_back(t1 + 13);
        wait_to(t1 + 14);

        // expected-LED checking
        led_mode = 1'b1;
        load(0, 8'h04, 16'd0, 8'h04);
        load(1, 8'h04, 16'd0, 8'h04);
        do_start(2, t0);
        push_cap(8'h05, t0 + 3);
        push_cap(8'h05, t0 + 6);
        done_q.push_back(t0 + 7);
        wait_to(t0 + 8);
`ifdef SWSEQ_CHECK_EN
        check("mismatch_two", 32'(bus.mismatch_cnt), 32'd2);
`else
        check("mismatch_tied", 32'(bus.mismatch_cnt), 32'd0);
`endif
        do_start(0, t1);
        done_q.push_back(t1 + 1);
        check("mismatch_cleared", 32'(bus.mismatch_cnt), 32'd0);
        wait_to(t1 + 2);
        led_mode = 1'b0;

        // asynchronous reset in the middle of GO
        load(0, 8'hA5, 16'd3, 8'd0);
        do_start(1, t0);
        wait_to(t0 + 6);
        check("rst_mid_in_go", 32'(bus.sw_go), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_sw_go", 32'(bus.sw_go), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_sw_data", 32'(bus.sw_data), 32'd0);
        check("rst_mid_cap_valid", 32'(bus.cap_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_state", 32'(bus.state), 32'd0);

        step();
        step();
        check("cap_queue_empty", exp_q.size(), 32'd0);
        check("done_queue_empty", done_q.size(), 32'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_sequencer.md
# sw_sequencer

Synthesisable, parametrised stimulus sequencer for the picoMIPS switch interface. It replays a loaded table of input vectors onto the processor's data switches and pulses the go/handshake switch with per-vector hold times. After each handshake it captures the LED output. It sits between a host/bench loader and the picoMIPS `SW`/`LED` ports, replacing hand-timed stimulus with a programmable, self-timed sequence.

## Interface
- `DATA_W`, 8, width of the data-switch vector driven to the DUT
- `LED_W`, 8, width of the captured DUT output
- `DEPTH`, 16, number of vector-table entries (power of two, ≥2)
- `HOLD_W`, 16, width of per-vector hold count
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin sequence (level sampled in IDLE)
- `abort`  in  1  synchronous abort to IDLE
- `vec_count`  in  $clog2(DEPTH)+1  number of entries to replay, sampled on start
- `load_we`  in  1  table write strobe
- `load_addr`  in  $clog2(DEPTH)  table write address
- `load_data`  in  DATA_W  switch value for entry
- `load_hold`  in  HOLD_W  hold count for entry
- `load_expect`  in  LED_W  expected LED value (used only with SWSEQ_CHECK_EN)
- `led_in`  in  LED_W  DUT output
- `sw_data`  out  DATA_W  data switches to DUT (registered)
- `sw_go`  out  1  handshake switch to DUT (registered)
- `cap_data`  out  LED_W  last captured `led_in`
- `cap_valid`  out  1  one-cycle pulse when `cap_data` updates
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on normal sequence completion
- `mismatch_cnt`  out  8  saturating mismatch count (SWSEQ_CHECK_EN only; else tied 0)

## Operation
- States: IDLE, SETUP, GO, CAPTURE, DONE.
- IDLE: if `start` and `vec_count`≠0, latch `vec_count` and set index←0. Go to SETUP. If `start` and `vec_count`=0, go to DONE directly.
- SETUP: `sw_data`←entry[index].data, `sw_go`=0. Stays hold+1 cycles, then GO.
- GO: `sw_go`=1 for hold+1 cycles, then CAPTURE.
- CAPTURE (1 cycle): `sw_go`←0, `cap_data`←`led_in`, `cap_valid`=1. If index = latched count−1, go to DONE; else index+1, go to SETUP.
- DONE (1 cycle): `done`=1, then IDLE.
- `vec_count` > DEPTH is clamped to DEPTH.
- Table writes are performed only when `busy`=0 and `start`=0; otherwise they are dropped.
- `start` while busy is ignored.
- `abort` in any non-IDLE state: next state IDLE, `sw_go`←0, no `done`, no `cap_valid`. `abort` has priority over every transition.
- `sw_data` holds its last value in IDLE/DONE.
- Reset mid-sequence: all outputs drop to reset values immediately; table contents undefined.

## Timing
- Reset values: `sw_data`=0, `sw_go`=0, `cap_data`=0, `cap_valid`=0, `busy`=0, `done`=0, `mismatch_cnt`=0, state IDLE.
- `start` accepted at edge n → SETUP and `busy`=1 from n+1.
- Per-vector cycles = 2·(hold+1)+1.
- `sw_data` is stable for at least one full cycle before `sw_go` rises. `sw_go` falls on the same edge the capture occurs.
- Sequence of N vectors: `done` at cycle 1+Σ(2·(hold_i+1)+1) after the start edge; `busy` falls the cycle after `done`.
- Hold counter is HOLD_W bits with no wrap: hold = 2^HOLD_W−1 is legal.

## Configuration
- `SWSEQ_CHECK_EN` defined: the table stores `load_expect`. In CAPTURE, a `led_in` ≠ expect increments `mismatch_cnt`, saturating at 255. `mismatch_cnt` clears on each accepted `start`.
- Undefined: no expect storage, `load_expect` ignored, `mismatch_cnt` constant 0.

## Test plan
- Reset asserted at 5 ns mid-GO → `sw_go`, `busy`, `sw_data` all 0 within the same cycle; state IDLE after release.
- Load entry0 = {data 0x02, hold 3}, `vec_count`=1, `start` → `sw_data`=0x02 with `sw_go`=0 for 4 cycles, then `sw_go`=1 for 4 cycles. `cap_valid` and `done` are 9 and 10 cycles after start.
- Three entries {0x01,0},{0x80,1},{0xFF,0} → `cap_valid` pulses at 3, 8, 11 cycles after start; `done` at 12.
- `vec_count`=0 → `done` one cycle after start; `sw_go` never rises.
- `abort` during the second GO → `busy`=0 next cycle, no `done`; a write issued while busy is dropped, confirmed by readback on replay.
- SWSEQ_CHECK_EN: expect 0x04 with `led_in`=0x05 on two vectors → `mismatch_cnt`=2; a new `start` clears it to 0.
